// File: rtl/ring_freq_counter_pkg.sv
// ============================================================================
// Module : ring_freq_counter_pkg
// Brief  : Shared FSM encoding and default sizing for the ring frequency counter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ring_freq_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GATE  = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_GATE_CYCLES = 1_000_000;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

`default_nettype wire

// File: rtl/ring_sync_edge.sv
// ============================================================================
// Module : ring_sync_edge
// Brief  : Multi-flop synchroniser for the raw ring output plus rising-edge pulse.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ring_sync_edge
  import ring_freq_counter_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ring_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ring_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/ring_freq_counter.sv
// ============================================================================
// Module : ring_freq_counter
// Brief  : Gated ring-oscillator edge counter; one result per window with a
//          one-cycle valid pulse. Optional macro RING_FREQ_AVG_EN selects a
//          running average over the last four windows.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ring_freq_counter
  import ring_freq_counter_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             fpga_clk1,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             ring_in,
  output logic [CNT_W-1:0] value_out,
  output logic             value_valid,
  output logic             overflow
);

  localparam int               GW        = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state_q, state_d;
  logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic             sat_q, sat_d;
  logic             valid_q;
  logic             rise;
  logic             latch;

  ring_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i (fpga_clk1),
    .rst_ni(reset_n),
    .ring_i(ring_in),
    .rise_o(rise)
  );

  assign latch = (state_q == ST_LATCH);

  always_ff @(posedge fpga_clk1 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sat_q      <= sat_d;
      valid_q    <= latch;
    end
  end

  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    sat_d      = sat_q;
    case (state_q)
      ST_IDLE: begin
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        sat_d      = 1'b0;
        if (enable) state_d = ST_GATE;
      end
      ST_GATE: begin
        gate_cnt_d = gate_cnt_q + GW'(1);
        if (rise) begin
          if (edge_cnt_q == CNT_MAX) sat_d = 1'b1;
          else                       edge_cnt_d = edge_cnt_q + CNT_W'(1);
        end
        // Abort takes priority over completing the window.
        if (!enable)                      state_d = ST_IDLE;
        else if (gate_cnt_q == GATE_LAST) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        sat_d      = 1'b0;
        state_d    = enable ? ST_GATE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign value_valid = valid_q;

`ifdef RING_FREQ_AVG_EN
  logic [CNT_W-1:0] hist_q [4];
  logic [3:0]       hsat_q;
  logic [CNT_W+1:0] sum;

  always_ff @(posedge fpga_clk1 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) hist_q[i] <= '0;
      hsat_q <= '0;
    end else if (latch) begin
      hist_q[0] <= edge_cnt_q;
      for (int i = 1; i < 4; i++) hist_q[i] <= hist_q[i-1];
      hsat_q <= {hsat_q[2:0], sat_q};
    end
  end

  // History only moves on LATCH, so the output holds between updates.
  always_comb begin
    sum = '0;
    for (int i = 0; i < 4; i++) sum = sum + {2'b00, hist_q[i]};
  end

  assign value_out = CNT_W'(sum >> 2);
  assign overflow  = |hsat_q;
`else
  logic [CNT_W-1:0] value_q;
  logic             ovf_q;

  always_ff @(posedge fpga_clk1 or negedge reset_n) begin
    if (!reset_n) begin
      value_q <= '0;
      ovf_q   <= 1'b0;
    end else if (latch) begin
      value_q <= edge_cnt_q;
      ovf_q   <= sat_q;
    end
  end

  assign value_out = value_q;
  assign overflow  = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ring_freq_counter.sv
// ============================================================================
// Module : tb_ring_freq_counter
// Brief  : Randomised self-checking bench against a sample-history model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ring_freq_counter;

  localparam int G = 100;
  localparam int S = 2;

  logic        clk, rst_n, en, en4, ring;
  logic [15:0] v16;
  logic [3:0]  v4;
  logic        vld16, vld4, ovf16, ovf4;

  int checks = 0;
  int errors = 0;

  ring_freq_counter #(.GATE_CYCLES(G), .CNT_W(16), .SYNC_STAGES(S)) dut (
    .fpga_clk1(clk), .reset_n(rst_n), .enable(en), .ring_in(ring),
    .value_out(v16), .value_valid(vld16), .overflow(ovf16)
  );

  ring_freq_counter #(.GATE_CYCLES(G), .CNT_W(4), .SYNC_STAGES(S)) dut4 (
    .fpga_clk1(clk), .reset_n(rst_n), .enable(en4), .ring_in(ring),
    .value_out(v4), .value_valid(vld4), .overflow(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ring waveform: edges only at 2 + 10*m, never on a clock edge.
  int ring_half = 0;
  bit ring_rand = 0;
  initial begin
    int h;
    ring = 1'b0;
    #2;
    forever begin
      if (ring_half == 0 && !ring_rand) begin
        ring = 1'b0;
        #10;
      end else begin
        h = ring_rand ? 10 * $urandom_range(2, 7) : ring_half;
        #(h);
        ring = ~ring;
      end
    end
  end

  // Ring level seen by each clock edge, indexed by edge number.
  bit samp [0:19999];
  int cyc = 0;
  always @(posedge clk) begin
    if (cyc < 20000) samp[cyc] = ring;
    cyc++;
  end

  // A sample-level 0->1 becomes visible to the counter S-1 edges later.
  function automatic int win_count(input int a, input int b);
    int c = 0;
    for (int n = a; n <= b; n++)
      if (samp[n-S+1] && !samp[n-S]) c++;
    return c;
  endfunction

  int hc [2][4];
  bit hs [2][4];

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) begin hc[d][i] = 0; hs[d][i] = 0; end
  endtask

  task automatic model_window(input int sel, input int raw, output int ev, output bit eo);
    int mx;
    int cnt;
    bit s;
    mx  = sel ? 15 : 65535;
    cnt = (raw > mx) ? mx : raw;
    s   = (raw > mx);
`ifdef RING_FREQ_AVG_EN
    for (int i = 3; i > 0; i--) begin hc[sel][i] = hc[sel][i-1]; hs[sel][i] = hs[sel][i-1]; end
    hc[sel][0] = cnt;
    hs[sel][0] = s;
    ev = (hc[sel][0] + hc[sel][1] + hc[sel][2] + hc[sel][3]) / 4;
    eo = hs[sel][0] | hs[sel][1] | hs[sel][2] | hs[sel][3];
`else
    ev = cnt;
    eo = s;
`endif
  endtask

  // Stimulus and capture only: enables one DUT for ncyc cycles, logs pulses.
  int run_n0;
  int obs_k[$];
  int obs_v[$];
  bit obs_o[$];

  task automatic run_windows(input bit use4, input int ncyc);
    @(negedge clk);
    if (use4) en4 = 1'b1; else en = 1'b1;
    run_n0 = cyc - 1;
    obs_k.delete(); obs_v.delete(); obs_o.delete();
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (use4 ? vld4 : vld16) begin
        obs_k.push_back(k);
        obs_v.push_back(use4 ? int'(v4) : int'(v16));
        obs_o.push_back(use4 ? ovf4 : ovf16);
      end
    end
    if (use4) en4 = 1'b0; else en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; en4 = 1'b1;
    ring_half = 20;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (v16 !== 16'd0 || vld16 !== 1'b0 || ovf16 !== 1'b0 || v4 !== 4'd0 || vld4 !== 1'b0 || ovf4 !== 1'b0) begin
        errors++;
        $display("FAIL reset cyc%0d: got v=%0d vld=%0b ovf=%0b v4=%0d vld4=%0b ovf4=%0b, want all 0",
                 i, v16, vld16, ovf16, v4, vld4, ovf4);
      end
    end
    en = 1'b0; en4 = 1'b0;
    rst_n = 1'b1;
    model_clear();
    repeat (5) @(negedge clk);
  endtask

  task automatic test_nominal();
    int ev; bit eo;
    ring_rand = 0; ring_half = 20;
    run_windows(0, 5 * (G + 1) + 1);
    checks++;
    if (obs_k.size() != 5) begin errors++; $display("FAIL nominal pulses: got %0d want 5", obs_k.size()); end
    for (int w = 0; w < 5; w++) begin
      model_window(0, win_count(run_n0 + 1 + w * (G + 1), run_n0 + w * (G + 1) + G), ev, eo);
      if (w < obs_k.size()) begin
        checks++;
        if (obs_k[w] !== (w + 1) * (G + 1) + 1 || obs_v[w] !== ev || obs_o[w] !== eo) begin
          errors++;
          $display("FAIL nominal w%0d: got k=%0d val=%0d ovf=%0b want k=%0d val=%0d ovf=%0b",
                   w, obs_k[w], obs_v[w], obs_o[w], (w + 1) * (G + 1) + 1, ev, eo);
        end
      end
    end
  endtask

  task automatic test_ring_stopped();
    int ev; bit eo;
    ring_rand = 0; ring_half = 0;
    run_windows(0, 2 * (G + 1) + 1);
    checks++;
    if (obs_k.size() != 2) begin errors++; $display("FAIL stopped pulses: got %0d want 2", obs_k.size()); end
    for (int w = 0; w < 2; w++) begin
      model_window(0, win_count(run_n0 + 1 + w * (G + 1), run_n0 + w * (G + 1) + G), ev, eo);
      if (w < obs_k.size()) begin
        checks++;
        if (obs_k[w] !== (w + 1) * (G + 1) + 1 || obs_v[w] !== ev || obs_o[w] !== eo) begin
          errors++;
          $display("FAIL stopped w%0d: got k=%0d val=%0d ovf=%0b want k=%0d val=%0d ovf=%0b",
                   w, obs_k[w], obs_v[w], obs_o[w], (w + 1) * (G + 1) + 1, ev, eo);
        end
      end
    end
  endtask

  task automatic test_random_ring();
    int ev; bit eo;
    ring_rand = 1;
    run_windows(0, 4 * (G + 1) + 1);
    checks++;
    if (obs_k.size() != 4) begin errors++; $display("FAIL random pulses: got %0d want 4", obs_k.size()); end
    for (int w = 0; w < 4; w++) begin
      model_window(0, win_count(run_n0 + 1 + w * (G + 1), run_n0 + w * (G + 1) + G), ev, eo);
      if (w < obs_k.size()) begin
        checks++;
        if (obs_k[w] !== (w + 1) * (G + 1) + 1 || obs_v[w] !== ev || obs_o[w] !== eo) begin
          errors++;
          $display("FAIL random w%0d: got k=%0d val=%0d ovf=%0b want k=%0d val=%0d ovf=%0b",
                   w, obs_k[w], obs_v[w], obs_o[w], (w + 1) * (G + 1) + 1, ev, eo);
        end
      end
    end
    ring_rand = 0;
  endtask

  task automatic test_saturation();
    int ev; bit eo;
    for (int r = 0; r < 2; r++) begin
      ring_half = (r == 0) ? 20 : 0;
      run_windows(1, (G + 1) + 1);
      model_window(1, win_count(run_n0 + 1, run_n0 + G), ev, eo);
      checks++;
      if (obs_k.size() != 1 || obs_k[0] !== G + 2 || obs_v[0] !== ev || obs_o[0] !== eo) begin
        errors++;
        $display("FAIL saturation run%0d: got pulses=%0d val=%0d ovf=%0b want pulses=1 val=%0d ovf=%0b",
                 r, obs_k.size(), (obs_v.size() > 0) ? obs_v[0] : -1, (obs_o.size() > 0) ? obs_o[0] : 1'b0, ev, eo);
      end
    end
  endtask

  task automatic test_abort();
    int ev; bit eo;
    ring_rand = 0; ring_half = 20;
    run_windows(0, (G + 1) + 50);
    model_window(0, win_count(run_n0 + 1, run_n0 + G), ev, eo);
    checks++;
    if (obs_k.size() != 1 || obs_k[0] !== G + 2 || obs_v[0] !== ev || obs_o[0] !== eo) begin
      errors++;
      $display("FAIL abort first window: got pulses=%0d val=%0d want pulses=1 val=%0d ovf=%0b",
               obs_k.size(), (obs_v.size() > 0) ? obs_v[0] : -1, ev, eo);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (vld16 !== 1'b0 || int'(v16) !== ev || ovf16 !== eo) begin
        errors++;
        $display("FAIL abort hold cyc%0d: got vld=%0b val=%0d ovf=%0b want vld=0 val=%0d ovf=%0b",
                 i, vld16, v16, ovf16, ev, eo);
      end
    end
    run_windows(0, (G + 1) + 1);
    model_window(0, win_count(run_n0 + 1, run_n0 + G), ev, eo);
    checks++;
    if (obs_k.size() != 1 || obs_k[0] !== G + 2 || obs_v[0] !== ev || obs_o[0] !== eo) begin
      errors++;
      $display("FAIL abort re-enable: got pulses=%0d k=%0d val=%0d want pulses=1 k=%0d val=%0d",
               obs_k.size(), (obs_k.size() > 0) ? obs_k[0] : -1, (obs_v.size() > 0) ? obs_v[0] : -1, G + 2, ev);
    end
  endtask

  task automatic test_reset_midrun();
    int ev; bit eo;
    ring_rand = 0; ring_half = 20;
    @(negedge clk);
    en = 1'b1;
    repeat (150) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (v16 !== 16'd0 || vld16 !== 1'b0 || ovf16 !== 1'b0 || v4 !== 4'd0 || ovf4 !== 1'b0) begin
      errors++;
      $display("FAIL reset midrun: got v=%0d vld=%0b ovf=%0b v4=%0d ovf4=%0b want all 0", v16, vld16, ovf16, v4, ovf4);
    end
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    repeat (5) @(negedge clk);
    run_windows(0, 2 * (G + 1) + 1);
    checks++;
    if (obs_k.size() != 2) begin errors++; $display("FAIL restart pulses: got %0d want 2", obs_k.size()); end
    for (int w = 0; w < 2; w++) begin
      model_window(0, win_count(run_n0 + 1 + w * (G + 1), run_n0 + w * (G + 1) + G), ev, eo);
      if (w < obs_k.size()) begin
        checks++;
        if (obs_k[w] !== (w + 1) * (G + 1) + 1 || obs_v[w] !== ev || obs_o[w] !== eo) begin
          errors++;
          $display("FAIL restart w%0d: got k=%0d val=%0d ovf=%0b want k=%0d val=%0d ovf=%0b",
                   w, obs_k[w], obs_v[w], obs_o[w], (w + 1) * (G + 1) + 1, ev, eo);
        end
      end
    end
  endtask

  initial begin
    en = 1'b0; en4 = 1'b0; rst_n = 1'b0;
    test_reset();
    test_nominal();
    test_ring_stopped();
    test_random_ring();
    test_saturation();
    test_abort();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
